// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scanner with shadowed data, blink and leading-zero blanking.
// Optional feature macro: SEG_HEX_EN (decode nibbles A-F as hex glyphs; otherwise they are blank).
// Ports:
//    clk        - clock, all logic on rising edge
//    rst        - synchronous active-high reset
//    digits     - 4*NUM_DIGITS nibbles, digit i at [4i+3:4i], captured on load
//    dp_in      - per-digit decimal point request, captured on load
//    load       - one-cycle strobe capturing digits/dp_in into shadow registers
//    blink_mask - live per-digit blink enable
//    blank_lz   - live leading-zero blanking enable
//    seg        - active-low segments {g,f,e,d,c,b,a}, registered
//    dp         - active-low decimal point, registered
//    an         - active-low digit enables, one-hot-low or all-high, registered
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 200000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [FW-1:0]           frm;
   logic                    phase;
   logic [4*NUM_DIGITS-1:0] sh_dig;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic                    tick;
   logic                    frame_end;
   logic [NUM_DIGITS-1:0]   lz;
   logic                    zr;
   logic [3:0]              nib;
   logic                    blank;

   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'h0:    dec = 7'b1000000;
         4'h1:    dec = 7'b1111001;
         4'h2:    dec = 7'b0100100;
         4'h3:    dec = 7'b0110000;
         4'h4:    dec = 7'b0011001;
         4'h5:    dec = 7'b0010010;
         4'h6:    dec = 7'b0000010;
         4'h7:    dec = 7'b1111000;
         4'h8:    dec = 7'b0000000;
         4'h9:    dec = 7'b0011000;
`ifdef SEG_HEX_EN
         4'hA:    dec = 7'b0001000;
         4'hB:    dec = 7'b0000011;
         4'hC:    dec = 7'b1000110;
         4'hD:    dec = 7'b0100001;
         4'hE:    dec = 7'b0000110;
         default: dec = 7'b0001110;
`else
         default: dec = 7'b1111111;
`endif
      endcase
   endfunction

   assign tick      = cnt == CW'(CLK_DIV - 1);
   assign frame_end = tick && idx == IW'(NUM_DIGITS - 1);
   assign nib       = sh_dig[{idx, 2'b00} +: 4];
   assign blank     = (blank_lz & lz[idx]) | (phase & blink_mask[idx]);

   // lz[i]: digit i and every digit above it are zero; digit 0 is exempt
   always_comb begin
      zr = 1'b1;
      lz = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zr    = zr & (sh_dig[4*i +: 4] == 4'd0);
         lz[i] = zr & (i > 0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         idx    <= '0;
         frm    <= '0;
         phase  <= 1'b0;
         sh_dig <= '0;
         sh_dp  <= '0;
         seg    <= '1;
         dp     <= 1'b1;
         an     <= '1;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (load) begin
            sh_dig <= digits;
            sh_dp  <= dp_in;
         end
         // outputs sample the pre-advance index and the pre-load shadow
         if (tick) begin
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            seg <= blank ? '1 : dec(nib);
            dp  <= blank | ~sh_dp[idx];
            an  <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
         end
         if (frame_end) begin
            frm   <= (frm == FW'(BLINK_FRAMES - 1)) ? '0 : frm + 1'b1;
            phase <= (frm == FW'(BLINK_FRAMES - 1)) ? ~phase : phase;
         end
      end
   end
endmodule
